// File: rtl/pbit_sched_pkg.sv
// Shared types and constants for the p-bit sweep scheduler.
package pbit_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } sched_state_e;

    localparam logic [1:0] BIT_SHIFT_MAX = 2'd3;

    function automatic bit settle_legal(input int settle);
        return (settle >= 1) && (settle <= 15);
    endfunction

endpackage

// File: rtl/pbit_anneal_ctr.sv
// Annealing code generator: bumps a saturating bit_shift every ANNEAL_SWEEPS sweeps.
module pbit_anneal_ctr
    import pbit_sched_pkg::*;
#(
    parameter int ANNEAL_SWEEPS = 0,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       sweep_hs,
    output logic [1:0] bit_shift
);

    localparam bit             EN   = ANNEAL_SWEEPS > 0;
    localparam logic [CNT_W-1:0] WRAP = CNT_W'(EN ? ANNEAL_SWEEPS - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (EN && sweep_hs) begin
            if (cnt_q == WRAP) begin
                cnt_d = '0;
                if (shift_q != BIT_SHIFT_MAX) shift_d = shift_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign bit_shift = shift_q;

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sequential Gibbs sweep sequencer: one-hot p-bit strobes, settle wait, per-sweep sample handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for start
// S_STROBE | pbit_clk = 1<<idx for one cycle, settle counter loaded
// S_SETTLE | settle down-count; advance idx or capture sample
// S_SAMPLE | sample offered, p-bits frozen until sample_ready
// S_DONE   | one-cycle done pulse
module pbit_sweep_scheduler
    import pbit_sched_pkg::*;
#(
    parameter int N_BITS        = 5,
    parameter int SETTLE        = 2,
    parameter int SWEEP_W       = 16,
    parameter int ANNEAL_SWEEPS = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic               abort,
    input  logic [N_BITS-1:0]  state_in,
    input  logic               sample_ready,
    output logic [N_BITS-1:0]  pbit_clk,
    output logic [1:0]         bit_shift,
    output logic               busy,
    output logic               done,
    output logic               sample_valid,
    output logic [N_BITS-1:0]  sample_data,
    output logic [SWEEP_W-1:0] sweep_count
);

    localparam int            IW        = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_BITS - 1);
    localparam logic [3:0]    SCNT_LOAD = 4'(SETTLE);

    generate
        if (!settle_legal(SETTLE)) begin : g_bad_settle
            $error("pbit_sweep_scheduler: SETTLE must be within 1..15");
        end
    endgenerate

    sched_state_e       state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         scnt_q, scnt_d;
    logic [SWEEP_W-1:0] limit_q, limit_d;
    logic [SWEEP_W-1:0] sweep_count_q, sweep_count_d;
    logic [N_BITS-1:0]  sample_data_q, sample_data_d;
    logic [N_BITS-1:0]  pbit_clk_q, pbit_clk_d;
    logic               sample_valid_q, sample_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               sweep_hs;
    logic               anneal_clr;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        scnt_d        = scnt_q;
        limit_d       = limit_q;
        sweep_count_d = sweep_count_q;
        sample_data_d = sample_data_q;
        sweep_hs      = 1'b0;
        anneal_clr    = 1'b0;

        // Abort wins over everything, including a same-cycle sample handshake.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        limit_d       = num_sweeps;
                        sweep_count_d = '0;
                        idx_d         = '0;
                        anneal_clr    = 1'b1;
                        state_d       = (num_sweeps == '0) ? S_DONE : S_STROBE;
                    end
                end
                S_STROBE: begin
                    scnt_d  = SCNT_LOAD;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (scnt_q == 4'd1) begin
                        if (idx_q != IDX_LAST) begin
                            idx_d   = idx_q + IW'(1);
                            state_d = S_STROBE;
                        end else begin
                            sample_data_d = state_in;
                            state_d       = S_SAMPLE;
                        end
                    end else begin
                        scnt_d = scnt_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (sample_ready) begin
                        sweep_hs      = 1'b1;
                        sweep_count_d = sweep_count_q + SWEEP_W'(1);
                        idx_d         = '0;
                        state_d       = (sweep_count_d == limit_q) ? S_DONE : S_STROBE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered off the next state so they line up with the state they describe.
        pbit_clk_d     = (state_d == S_STROBE) ? (N_BITS'(1) << idx_d) : '0;
        sample_valid_d = (state_d == S_SAMPLE);
        done_d         = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            scnt_q         <= '0;
            limit_q        <= '0;
            sweep_count_q  <= '0;
            sample_data_q  <= '0;
            pbit_clk_q     <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            scnt_q         <= scnt_d;
            limit_q        <= limit_d;
            sweep_count_q  <= sweep_count_d;
            sample_data_q  <= sample_data_d;
            pbit_clk_q     <= pbit_clk_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    pbit_anneal_ctr #(
        .ANNEAL_SWEEPS(ANNEAL_SWEEPS),
        .CNT_W        (SWEEP_W)
    ) u_anneal (
        .clk      (clk),
        .reset    (reset),
        .clear    (anneal_clr),
        .sweep_hs (sweep_hs),
        .bit_shift(bit_shift)
    );

    assign pbit_clk     = pbit_clk_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign sweep_count  = sweep_count_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Directed bench for pbit_sweep_scheduler: default instance plus an ANNEAL_SWEEPS=2 instance on shared stimulus.
module tb_pbit_sweep_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_sweeps;
    logic        abort;
    logic [4:0]  state_in;
    logic        sample_ready;

    logic [4:0]  pbit_clk,     an_pbit_clk;
    logic [1:0]  bit_shift,    an_bit_shift;
    logic        busy,         an_busy;
    logic        done,         an_done;
    logic        sample_valid, an_sample_valid;
    logic [4:0]  sample_data,  an_sample_data;
    logic [15:0] sweep_count,  an_sweep_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pbit_sweep_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps), .abort(abort),
        .state_in(state_in), .sample_ready(sample_ready), .pbit_clk(pbit_clk),
        .bit_shift(bit_shift), .busy(busy), .done(done), .sample_valid(sample_valid),
        .sample_data(sample_data), .sweep_count(sweep_count)
    );

    pbit_sweep_scheduler #(.ANNEAL_SWEEPS(2)) dut_an (
        .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps), .abort(abort),
        .state_in(state_in), .sample_ready(sample_ready), .pbit_clk(an_pbit_clk),
        .bit_shift(an_bit_shift), .busy(an_busy), .done(an_done), .sample_valid(an_sample_valid),
        .sample_data(an_sample_data), .sweep_count(an_sweep_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1: the cycle after start was sampled.
    task automatic launch(input logic [15:0] ns);
        num_sweeps = ns;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // One unstalled sweep with default timing, entered at cycle 1.
    task automatic single_run(input string tag, input logic [4:0] sd_exp);
        for (int c = 1; c <= 18; c++) begin
            logic [4:0] exp_clk;
            exp_clk = '0;
            if (c <= 13 && ((c - 1) % 3) == 0) exp_clk = 5'd1 << ((c - 1) / 3);
            chk($sformatf("%s_clk_c%0d", tag, c), pbit_clk, exp_clk);
            chk($sformatf("%s_valid_c%0d", tag, c), sample_valid, c == 16);
            chk($sformatf("%s_done_c%0d", tag, c), done, c == 17);
            chk($sformatf("%s_busy_c%0d", tag, c), busy, c <= 17);
            if (c == 16) chk({tag, "_data"}, sample_data, sd_exp);
            if (c == 17) chk({tag, "_count"}, sweep_count, 1);
            step();
        end
    endtask

    initial begin
        int n_strobe;
        int n_valid;
        int n_done;

        reset = 1'b1; start = 1'b0; num_sweeps = '0; abort = 1'b0;
        state_in = '0; sample_ready = 1'b1;
        repeat (3) step();
        chk("rst_pbit_clk", pbit_clk, 0);
        chk("rst_bit_shift", bit_shift, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_count", sweep_count, 0);
        reset = 1'b0;
        step();

        // Single unstalled sweep.
        state_in = 5'b01101;
        launch(16'd1);
        single_run("s1", 5'b01101);

        // Three sweeps with a 4-cycle stall on sweep 2; state_in wiggles during the stall.
        state_in = 5'b10110;
        n_strobe = 0; n_valid = 0; n_done = 0;
        launch(16'd3);
        for (int c = 1; c <= 56; c++) begin
            sample_ready = !(c >= 17 && c <= 35);
            if (c >= 33 && c <= 35) state_in = 5'b01001;
            if (c == 36) state_in = 5'b10110;
            if (pbit_clk != 0) n_strobe++;
            if (sample_valid) n_valid++;
            if (done) n_done++;
            if (c >= 32 && c <= 35) begin
                chk($sformatf("stall_valid_c%0d", c), sample_valid, 1);
                chk($sformatf("stall_data_c%0d", c), sample_data, 5'b10110);
                chk($sformatf("stall_clk_c%0d", c), pbit_clk, 0);
                chk($sformatf("stall_count_c%0d", c), sweep_count, 1);
            end
            if (c == 37) chk("stall_resume_clk", pbit_clk, 5'b00001);
            if (c == 52) chk("s3_data", sample_data, 5'b10110);
            if (c == 53) begin
                chk("s3_done", done, 1);
                chk("s3_count", sweep_count, 3);
            end
            step();
        end
        sample_ready = 1'b1;
        chk("s3_strobes", n_strobe, 15);
        chk("s3_valid_cycles", n_valid, 7);
        chk("s3_done_pulses", n_done, 1);

        // Ten sweeps: anneal instance steps bit_shift every 2 sweeps, default instance stays 0.
        launch(16'd10);
        for (int c = 1; c <= 162; c++) begin
            if (c > 1 && ((c - 1) % 16) == 0) begin
                int k;
                int exp_bs;
                k = (c - 1) / 16;
                exp_bs = (k / 2 > 3) ? 3 : k / 2;
                chk($sformatf("anneal_bs_sweep%0d", k), an_bit_shift, exp_bs);
                chk($sformatf("noanneal_bs_sweep%0d", k), bit_shift, 0);
            end
            if (c == 161) begin
                chk("anneal_done", an_done, 1);
                chk("anneal_count", an_sweep_count, 10);
            end
            if (c == 162) chk("anneal_busy_end", an_busy, 0);
            step();
        end
        chk("anneal_bs_held", an_bit_shift, 3);

        // Zero sweeps: done right away, no strobes or samples; start clears bit_shift.
        n_strobe = 0; n_valid = 0;
        launch(16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_an_bs_clear", an_bit_shift, 0);
        for (int c = 1; c <= 4; c++) begin
            if (pbit_clk != 0) n_strobe++;
            if (sample_valid) n_valid++;
            if (c == 2) begin
                chk("zero_done_gone", done, 0);
                chk("zero_idle", busy, 0);
            end
            step();
        end
        chk("zero_strobes", n_strobe, 0);
        chk("zero_valid", n_valid, 0);

        // Abort during SETTLE of sweep 2.
        state_in = 5'b00111;
        launch(16'd5);
        for (int c = 1; c <= 18; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_clk", pbit_clk, 0);
        chk("abort_done", done, 0);
        chk("abort_count", sweep_count, 1);
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) n_done++;
            step();
        end
        chk("abort_no_done", n_done, 0);
        launch(16'd1);
        single_run("abort_rerun", 5'b00111);

        // Abort coinciding with a sample handshake: the sample is not taken.
        launch(16'd2);
        for (int c = 1; c <= 15; c++) step();
        chk("abhs_valid", sample_valid, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abhs_busy", busy, 0);
        chk("abhs_count", sweep_count, 0);
        chk("abhs_valid_drop", sample_valid, 0);
        step();

        // Start and abort together in IDLE: start wins.
        num_sweeps = 16'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1);
        chk("sa_clk", pbit_clk, 5'b00001);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("sa_abort_idle", busy, 0);
        step();

        // Reset while sweep 2's sample is stalled.
        state_in = 5'b11011;
        launch(16'd2);
        for (int c = 1; c <= 31; c++) begin
            sample_ready = (c <= 16);
            step();
        end
        sample_ready = 1'b0;
        chk("rsamp_valid", sample_valid, 1);
        chk("rsamp_count", sweep_count, 1);
        reset = 1'b1;
        step();
        chk("rmid_pbit_clk", pbit_clk, 0);
        chk("rmid_bit_shift", bit_shift, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_valid", sample_valid, 0);
        chk("rmid_data", sample_data, 0);
        chk("rmid_count", sweep_count, 0);
        reset = 1'b0;
        sample_ready = 1'b1;
        step();
        state_in = 5'b01101;
        launch(16'd1);
        single_run("rst_rerun", 5'b01101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
